// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and width helpers for the alu_muldiv execute unit
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD_SUB = 3'd0,
        OP_SLL     = 3'd1,
        OP_SLT     = 3'd2,
        OP_SLTU    = 3'd3,
        OP_XOR     = 3'd4,
        OP_SRL_SRA = 3'd5,
        OP_OR      = 3'd6,
        OP_AND     = 3'd7
    } base_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } md_state_e;

    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

    function automatic logic md_a_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_b_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider on operand magnitudes
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            start,
    input  md_op_e          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int SHW = shamt_w(XLEN);

    logic            r_active;
    logic [SHW-1:0]  r_cnt;
    md_op_e          r_op;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_mcand;
    logic            r_neg_res;
    logic            r_neg_rem;

    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_is_div;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_sub;
    logic [XLEN-1:0] w_next_hi;
    logic [XLEN-1:0] w_next_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;

    assign w_neg_a = md_a_signed(op) & a[XLEN-1];
    assign w_neg_b = md_b_signed(op) & b[XLEN-1];
    assign w_mag_a = w_neg_a ? -a : a;
    assign w_mag_b = w_neg_b ? -b : b;
    assign w_is_div = r_op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};

    // r_lo holds the multiplier (consumed LSB first) or the dividend (consumed MSB first)
    always_comb begin
        w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
        w_shift   = {r_hi, r_lo[XLEN-1]};
        w_ge      = (w_shift >= {1'b0, r_mcand});
        w_rem_sub = w_shift[XLEN-1:0] - r_mcand;
        if (w_is_div) begin
            w_next_hi = w_ge ? w_rem_sub : w_shift[XLEN-1:0];
            w_next_lo = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_next_hi = w_sum[XLEN:1];
            w_next_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    assign w_prod   = {w_next_hi, w_next_lo};
    assign w_prod_s = r_neg_res ? -w_prod : w_prod;

    always_comb begin
        result = '0;
        case (r_op)
            MD_MUL:                       result = w_prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = w_prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = r_neg_res ? -w_next_lo : w_next_lo;
            MD_REM, MD_REMU:              result = r_neg_rem ? -w_next_hi : w_next_hi;
            default:                      result = '0;
        endcase
    end

    assign done = r_active & (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_op      <= MD_MUL;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mcand   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (kill) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (start) begin
            r_active  <= 1'b1;
            r_cnt     <= SHW'(XLEN-1);
            r_op      <= op;
            r_hi      <= '0;
            r_lo      <= w_mag_a;
            r_mcand   <= w_mag_b;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
        end else if (r_active) begin
            r_hi <= w_next_hi;
            r_lo <= w_next_lo;
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - RV32IM execute unit: single-cycle base ALU plus iterative mul/div
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      fn3,
    input  logic            fn7_bit5,
    input  logic            fn7_bit0,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SHW = shamt_w(XLEN);

    md_state_e       r_state;
    md_state_e       w_state_next;
    logic [XLEN-1:0] r_result;

    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;
    logic [XLEN-1:0] w_quick;
    logic            w_accept;
    logic            w_start;
    logic            w_load_quick;
    logic            w_load_md;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;

    assign w_shamt = b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (base_op_e'(fn3))
            OP_ADD_SUB: w_alu = fn7_bit5 ? (a - b) : (a + b);
            OP_SLL:     w_alu = a << w_shamt;
            OP_SLT:     w_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:    w_alu = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:     w_alu = a ^ b;
            OP_SRL_SRA: w_alu = fn7_bit5 ? XLEN'($signed(a) >>> w_shamt) : (a >> w_shamt);
            OP_OR:      w_alu = a | b;
            OP_AND:     w_alu = a & b;
            default:    w_alu = '0;
        endcase
    end

    // Divide-by-zero and signed overflow finish in one cycle and bypass the engine
    assign w_b_zero      = (b == '0);
    assign w_ovf         = ~fn3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    assign w_special     = fn7_bit0 & fn3[2] & (w_b_zero | w_ovf);
    assign w_special_val = w_b_zero ? (fn3[1] ? a : '1) : (fn3[1] ? '0 : a);
    assign w_quick       = fn7_bit0 ? w_special_val : w_alu;

    assign in_ready     = ~flush & ((r_state == IDLE) | ((r_state == HOLD) & out_ready));
    assign w_accept     = in_valid & in_ready;
    assign w_start      = w_accept & fn7_bit0 & ~w_special;
    assign w_load_quick = w_accept & (~fn7_bit0 | w_special);
    assign w_load_md    = (r_state == RUN) & w_md_done & ~flush;

    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state == RUN);
    assign result    = r_result;

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .kill   (flush),
        .start  (w_start),
        .op     (md_op_e'(fn3)),
        .a      (a),
        .b      (b),
        .done   (w_md_done),
        .result (w_md_result)
    );

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) w_state_next = w_start ? RUN : HOLD;
                end
                RUN: begin
                    if (w_md_done) w_state_next = HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        if (w_accept) w_state_next = w_start ? RUN : HOLD;
                        else          w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_quick) begin
                r_result <= w_quick;
            end else if (w_load_md) begin
                r_result <= w_md_result;
            end
        end
    end

endmodule
